// File: rtl/pri_encoder_seq.sv
// Sequential 8-to-3 encoder: accumulates request lines into a pending register and
// offers one index at a time over valid/ready, clearing each bit once it is accepted.
module pri_encoder_seq #(
  parameter int RR_MODE = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       en,
  input  logic       ready,
  output logic [2:0] code,
  output logic       valid,
  output logic [7:0] pend,
  output logic       any_pend
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t     state, state_d;
  logic [2:0] code_q, code_d;
  logic [2:0] last_code, last_d;
  logic [2:0] sel_code, idx;
  logic [7:0] pend_q, pend_d, clr;
  logic       found;

  // Fixed mode keeps the highest set bit; round-robin takes the first set bit after last_code.
  always_comb begin
    sel_code = '0;
    idx      = '0;
    found    = 1'b0;
    if (RR_MODE == 0) begin
      for (int unsigned i = 0; i < 8; i++) begin
        if (pend_q[i]) sel_code = 3'(i);
      end
    end else begin
      for (int unsigned k = 1; k <= 8; k++) begin
        idx = last_code + 3'(k);
        if (!found && pend_q[idx]) begin
          sel_code = idx;
          found    = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d = state;
    code_d  = code_q;
    last_d  = last_code;
    clr     = '0;
    case (state)
      IDLE: begin
        if (en && (pend_q != '0)) begin
          code_d  = sel_code;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (ready) begin
          clr[code_q] = 1'b1;
          last_d      = code_q;
          state_d     = IDLE;
        end
      end
    endcase
    // A request arriving on the same edge as the clear keeps the bit set.
    pend_d = (pend_q & ~clr) | req;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      code_q    <= '0;
      last_code <= '1;
      pend_q    <= '0;
    end else begin
      state     <= state_d;
      code_q    <= code_d;
      last_code <= last_d;
      pend_q    <= pend_d;
    end
  end

  assign code     = code_q;
  assign valid    = (state == HOLD);
  assign pend     = pend_q;
  assign any_pend = |pend_q;

endmodule

// File: tb/tb_pri_encoder_seq.sv
// Directed bench for pri_encoder_seq: one fixed-priority and one round-robin instance,
// accepted codes checked against per-instance expectation queues.
module tb_pri_encoder_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req_f, req_r;
  logic       en_f, en_r, ready_f, ready_r;
  logic [2:0] code_f, code_r;
  logic       valid_f, valid_r, anyp_f, anyp_r;
  logic [7:0] pend_f, pend_r;

  logic [2:0] q_f[$];
  logic [2:0] q_r[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pri_encoder_seq #(.RR_MODE(0)) u_fix (
    .clk(clk), .rst_n(rst_n), .req(req_f), .en(en_f), .ready(ready_f),
    .code(code_f), .valid(valid_f), .pend(pend_f), .any_pend(anyp_f)
  );

  pri_encoder_seq #(.RR_MODE(1)) u_rr (
    .clk(clk), .rst_n(rst_n), .req(req_r), .en(en_r), .ready(ready_r),
    .code(code_r), .valid(valid_r), .pend(pend_r), .any_pend(anyp_r)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then step past it so inputs can change and outputs are settled.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Handshakes complete at the next rising edge; inputs only change just after rising edges.
  always @(negedge clk) begin
    if (valid_f && ready_f) begin
      if (q_f.size() == 0) chk("fix_unexpected_accept", {5'd0, code_f}, 8'hEE);
      else chk("fix_accept_code", {5'd0, code_f}, {5'd0, q_f.pop_front()});
    end
    if (valid_r && ready_r) begin
      if (q_r.size() == 0) chk("rr_unexpected_accept", {5'd0, code_r}, 8'hEE);
      else chk("rr_accept_code", {5'd0, code_r}, {5'd0, q_r.pop_front()});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [2:0] exp_codes [3];
    rst_n = 1'b0; req_f = 8'hFF; req_r = 8'h00;
    en_f = 1'b1; en_r = 1'b1; ready_f = 1'b0; ready_r = 1'b0;

    // Reset held two edges with all requests active
    cyc(); cyc();
    chk("rst_pend", pend_f, 8'h00);
    chk("rst_valid", {7'd0, valid_f}, 8'h00);
    chk("rst_code", {5'd0, code_f}, 8'h00);
    chk("rst_any_pend", {7'd0, anyp_f}, 8'h00);
    rst_n = 1'b1;
    cyc();
    chk("rel_pend", pend_f, 8'hFF);
    chk("rel_valid_e1", {7'd0, valid_f}, 8'h00);
    cyc();
    chk("rel_valid_e2", {7'd0, valid_f}, 8'h01);
    chk("rel_code_e2", {5'd0, code_f}, 8'h07);
    req_f = 8'h00; ready_f = 1'b1;
    for (int i = 7; i >= 0; i--) q_f.push_back(3'(i));
    for (int i = 7; i >= 0; i--) begin
      chk("drain_valid_hi", {7'd0, valid_f}, 8'h01);
      chk("drain_code", {5'd0, code_f}, 8'(i));
      cyc();
      chk("drain_valid_lo", {7'd0, valid_f}, 8'h00);
      cyc();
    end
    chk("drain_pend", pend_f, 8'h00);

    // Fixed priority: 1001_0100 -> 7,4,2
    exp_codes[0] = 3'd7; exp_codes[1] = 3'd4; exp_codes[2] = 3'd2;
    req_f = 8'b1001_0100;
    for (int i = 0; i < 3; i++) q_f.push_back(exp_codes[i]);
    cyc();
    req_f = 8'h00;
    chk("fp_pend_latched", pend_f, 8'h94);
    chk("fp_valid_first_lo", {7'd0, valid_f}, 8'h00);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("fp_valid_hi", {7'd0, valid_f}, 8'h01);
      chk("fp_code", {5'd0, code_f}, {5'd0, exp_codes[i]});
      cyc();
      chk("fp_valid_lo", {7'd0, valid_f}, 8'h00);
    end
    chk("fp_pend_empty", pend_f, 8'h00);
    chk("fp_any_pend", {7'd0, anyp_f}, 8'h00);

    // Backpressure: code 5 held for 6 cycles while req[7] keeps arriving
    ready_f = 1'b0; req_f = 8'h20;
    q_f.push_back(3'd5); q_f.push_back(3'd7);
    cyc();
    req_f = 8'h80;
    cyc();
    for (int i = 0; i < 6; i++) begin
      chk("bp_valid", {7'd0, valid_f}, 8'h01);
      chk("bp_code", {5'd0, code_f}, 8'h05);
      cyc();
    end
    chk("bp_pend", pend_f, 8'hA0);
    ready_f = 1'b1; req_f = 8'h00;
    cyc();
    chk("bp_pend_after_accept", pend_f, 8'h80);
    cyc();
    chk("bp_next_code", {5'd0, code_f}, 8'h07);
    cyc();
    ready_f = 1'b0;
    chk("bp_pend_empty", pend_f, 8'h00);

    // Set wins over clear on the same bit
    req_f = 8'h08;
    q_f.push_back(3'd3); q_f.push_back(3'd3);
    cyc();
    req_f = 8'h00;
    cyc();
    chk("sw_code", {5'd0, code_f}, 8'h03);
    ready_f = 1'b1; req_f = 8'h08;
    cyc();
    req_f = 8'h00;
    chk("sw_pend_kept", pend_f, 8'h08);
    chk("sw_valid_lo", {7'd0, valid_f}, 8'h00);
    cyc();
    chk("sw_reoffer_valid", {7'd0, valid_f}, 8'h01);
    chk("sw_reoffer_code", {5'd0, code_f}, 8'h03);
    cyc();
    ready_f = 1'b0;
    chk("sw_pend_empty", pend_f, 8'h00);

    // Round-robin: after reset search starts at 0, then last_code=2 with 1000_0101 -> 7,0,2
    ready_r = 1'b1; req_r = 8'h81;
    q_r.push_back(3'd0); q_r.push_back(3'd7);
    cyc(); req_r = 8'h00;
    cyc();
    chk("rr_first_after_rst", {5'd0, code_r}, 8'h00);
    cyc(); cyc();
    chk("rr_second", {5'd0, code_r}, 8'h07);
    cyc();
    req_r = 8'h04;
    q_r.push_back(3'd2);
    cyc(); req_r = 8'h00;
    cyc();
    chk("rr_set_last2", {5'd0, code_r}, 8'h02);
    cyc();
    exp_codes[0] = 3'd7; exp_codes[1] = 3'd0; exp_codes[2] = 3'd2;
    req_r = 8'b1000_0101;
    for (int i = 0; i < 3; i++) q_r.push_back(exp_codes[i]);
    cyc(); req_r = 8'h00;
    chk("rr_pend_latched", pend_r, 8'h85);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("rr_valid_hi", {7'd0, valid_r}, 8'h01);
      chk("rr_code", {5'd0, code_r}, {5'd0, exp_codes[i]});
      cyc();
    end
    ready_r = 1'b0;
    chk("rr_pend_empty", pend_r, 8'h00);

    // en=0 freezes selection; reset during HOLD drops the offer
    en_f = 1'b0; req_f = 8'h0F;
    cyc(); req_f = 8'h00;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("en0_valid", {7'd0, valid_f}, 8'h00);
      chk("en0_pend", pend_f, 8'h0F);
    end
    en_f = 1'b1;
    cyc();
    chk("en1_valid", {7'd0, valid_f}, 8'h01);
    chk("en1_code", {5'd0, code_f}, 8'h03);
    en_f = 1'b0;
    cyc();
    chk("hold_en0_valid", {7'd0, valid_f}, 8'h01);
    chk("hold_en0_code", {5'd0, code_f}, 8'h03);
    rst_n = 1'b0;
    cyc();
    chk("midrst_valid", {7'd0, valid_f}, 8'h00);
    chk("midrst_pend", pend_f, 8'h00);
    rst_n = 1'b1; en_f = 1'b1;
    cyc(); cyc();
    chk("midrst_no_reoffer", {7'd0, valid_f}, 8'h00);
    chk("midrst_any_pend", {7'd0, anyp_f}, 8'h00);

    cyc();
    chk("fix_queue_empty", 8'(q_f.size()), 8'h00);
    chk("rr_queue_empty", 8'(q_r.size()), 8'h00);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
